// File: rtl/seq_detect_pkg.sv
// Shared defaults and types for the programmable serial sequence detector.
// Reset configuration detects "1010" with overlapping matches.
package seq_detect_pkg;
   localparam int DEF_MAX_LEN = 16;
   localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

   typedef logic [LEN_W-1:0] len_t;

   localparam logic [31:0] DEF_PATTERN = 32'h0000_000A;
   localparam len_t        DEF_LEN     = len_t'(4);
   localparam logic        DEF_OVERLAP = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment lands on 1 so the coincident event is not lost.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= W'(inc);
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: shift register, fill counter and a
// length-masked compare, with a saturating match counter.
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_bit,
   input  logic                         cfg_we,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         cnt_clr,
   output logic                         detected,
   output logic [CNT_W-1:0]             match_count,
   output logic                         cfg_err
);

   localparam int LW = $clog2(MAX_LEN + 1);

   logic [MAX_LEN-1:0] shift_q, pattern_q, shift_nxt, mask;
   logic [LW-1:0]      len_q, fill_q;
   logic               overlap_q, cfg_ok, full_enough, match;

   assign shift_nxt = {shift_q[MAX_LEN-2:0], in_bit};

   // Only the low len bits take part in the compare.
   for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
      assign mask[i] = (len_q > LW'(i));
   end

   assign cfg_ok      = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));
   // len is always >= 2, so len-1 cannot underflow; this is fill+1 >= len.
   assign full_enough = (fill_q >= (len_q - LW'(1)));
   assign match       = in_valid && !cfg_we && full_enough &&
                        ((shift_nxt & mask) == (pattern_q & mask));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q   <= '0;
         fill_q    <= '0;
         detected  <= 1'b0;
         cfg_err   <= 1'b0;
         pattern_q <= DEF_PATTERN[MAX_LEN-1:0];
         len_q     <= LW'(DEF_LEN);
         overlap_q <= DEF_OVERLAP;
      end else begin
         detected <= match;
         cfg_err  <= cfg_we && !cfg_ok;
         // A config write always swallows the beat, legal or not.
         if (cfg_we) begin
            if (cfg_ok) begin
               pattern_q <= cfg_pattern;
               len_q     <= cfg_len;
               overlap_q <= cfg_overlap;
               shift_q   <= '0;
               fill_q    <= '0;
            end
         end else if (in_valid) begin
            shift_q <= shift_nxt;
            if (match && !overlap_q)
               fill_q <= '0;
            else if (fill_q != LW'(MAX_LEN))
               fill_q <= fill_q + LW'(1);
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (match),
      .cnt (match_count)
   );

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the match counter width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  qualifies in_bit; no shift occurs when in_valid is low.
REQ-006 in_bit  input  1  serial data bit.
REQ-007 cfg_we  input  1  single-cycle configuration write strobe.
REQ-008 cfg_pattern  input  MAX_LEN  pattern to load; bit [len-1] is first-received, bit [0] is last-received.
REQ-009 cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits.
REQ-010 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-011 cnt_clr  input  1  synchronous clear of match_count.
REQ-012 detected  output  1  registered one-cycle match pulse.
REQ-013 match_count  output  CNT_W  saturating count of matches.
REQ-014 cfg_err  output  1  one-cycle pulse on a rejected configuration write.

Function
REQ-015 On in_valid=1, the shift register SHALL load {shift[MAX_LEN-2:0], in_bit}, and the fill counter SHALL increment, saturating at MAX_LEN.
REQ-016 A match SHALL occur on a cycle with in_valid=1 when fill+1 >= len and the next shift value, restricted to bits [len-1:0], equals pattern[len-1:0]; bits at or above len are ignored.
REQ-017 detected SHALL be 1 in the cycle after the matching in_valid beat, for exactly one cycle, and 0 otherwise.
REQ-018 Overlap mode: the fill counter is unaffected by a match, so a match may share bits with the previous match.
REQ-019 Non-overlap mode: on a match, the fill counter SHALL clear to 0, so the next match requires len fresh bits.
REQ-020 A cfg_we with 2 <= cfg_len <= MAX_LEN SHALL load the pattern, len and overlap registers.
REQ-021 A legal cfg_we SHALL also clear the shift register, the fill counter and detected on the next cycle.
REQ-022 A cfg_we with cfg_len < 2 or cfg_len > MAX_LEN SHALL leave the configuration and shift state unchanged and pulse cfg_err for one cycle.
REQ-023 When cfg_we and in_valid are both asserted, cfg_we SHALL win and the in_bit SHALL be discarded; this holds for legal and illegal writes.
REQ-024 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-025 When cnt_clr and a match occur in the same cycle, match_count SHALL become 1.
REQ-026 When cnt_clr is asserted without a match, match_count SHALL become 0.
REQ-027 Detection latency SHALL be 1 clock from the last pattern bit; there is no back-pressure, and a bit is accepted on every in_valid cycle.

Reset
REQ-028 While rst=0, all of the following SHALL be forced asynchronously: shift register 0, fill counter 0, detected 0, match_count 0, cfg_err 0.
REQ-029 On reset, the configuration registers SHALL take defaults pattern=4'b1010, len=4, overlap=1, so the block detects "1010" with overlap out of reset.
REQ-030 Reset deassertion mid-stream SHALL restart detection with fill=0; no match may use bits received before reset.

Structure
REQ-031 Package seq_detect_pkg SHALL hold the MAX_LEN default, the length type (len_t), and the reset-default pattern/length/overlap constants.
REQ-032 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clr, inc; output cnt) implementing REQ-024 through REQ-026.
REQ-033 The remaining logic SHALL consist of the shift register, the fill counter and the masked compare, with no FSM beyond the fill counter.

Verification
REQ-034 Default config, stream 0011_0101_1001_1001_1010_1000 -> detected pulses at the 3 overlapping "1010" completions; match_count=3.
REQ-035 Config "110011", len=6, overlap=0, stream 1100110011 -> exactly one pulse, after bit 6; the second match at bit 10 is suppressed in non-overlap mode. With overlap=1 -> pulses after bits 6 and 10.
REQ-036 Config len=8, pattern 8'hA5, in_valid toggling every other cycle around the pattern bits -> one pulse, 1 cycle after the 8th valid beat; no pulse while in_valid=0.
REQ-037 cfg_len=1 and cfg_len=MAX_LEN+1 writes -> cfg_err pulses, and detection of the prior pattern continues uninterrupted. A cfg_we issued in the same cycle as the final pattern bit -> no pulse, and fill is cleared.
REQ-038 CNT_W=2, 5 matches -> match_count reads 1,2,3,3,3. cnt_clr on the cycle of the 6th match -> match_count=1.
REQ-039 Assert rst mid-pattern ("101" received), release, send "0" -> no pulse; send a full "1010" -> one pulse.
